uled_share_arbiter: RTL and testbench

//  Shares the board's 10 user LEDs between NREQ on-chip display requesters (e.g. free-running

---
 rtl/uled_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_uled_share_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uled_share_arbiter.sv
// uled_share_arbiter
//   Shares one LED bus between NREQ display requesters. A round-robin
//   arbiter hands the LEDs to one requester at a time and keeps each grant
//   for up to HOLD cycles, so a person can read the pattern before the next
//   owner takes over.
//
// Ports
//   CLK          system clock
//   RST          synchronous, active-high reset
//   REQ          per-requester display request (level)
//   LED_DATA     requester i pattern in bits [i*LEDW +: LEDW]
//   GNT          one-hot grant, registered
//   GNT_VLD      |GNT, registered
//   SLOT_END     high on the last cycle of any grant
//   ULED         pattern of the current owner, one cycle behind GNT
//   dbg_state_o  FSM state (0 = IDLE, 1 = OWN)
//
// Request/grant protocol: a requester holds REQ high for as long as it wants
// the LEDs. GNT[i] goes high the cycle after the decision that picked i, and
// stays high while REQ[i] is held, up to HOLD cycles. Dropping REQ[i] ends
// the grant right away; SLOT_END marks that final cycle. A request from a
// non-owner is only looked at when a decision is due, so it never preempts
// the current owner.
module uled_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LEDW = 10,
  parameter int HOLD = 50_000_000,
  parameter int CNTW = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*LEDW-1:0] LED_DATA,
  output logic [NREQ-1:0]      GNT,
  output logic                 GNT_VLD,
  output logic                 SLOT_END,
  output logic [LEDW-1:0]      ULED,
  output logic                 dbg_state_o
);

  localparam int PW = $clog2(NREQ);
  localparam logic [CNTW-1:0] LAST = CNTW'(HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   own_q;
  logic [CNTW-1:0] timer_q;
  logic [NREQ-1:0] gnt_q;
  logic            vld_q;
  logic [LEDW-1:0] uled_q;

  // Arbitration result for the current cycle.
  logic            arb_hit_d;
  logic [PW-1:0]   arb_idx_d;
  logic [PW:0]     scan_pos;
  logic [PW-1:0]   rr_d;
  logic [NREQ-1:0] gnt_d;

  logic            owner_req;
  logic            expire;
  logic            slot_end;
  logic [LEDW-1:0] led_sel;

  // Scan REQ starting at rr_q, wrapping modulo NREQ. One extra bit in
  // scan_pos keeps rr_q + k from overflowing before the wrap when NREQ is
  // not a power of two.
  always_comb begin
    arb_hit_d = 1'b0;
    arb_idx_d = '0;
    scan_pos  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_pos = {1'b0, rr_q} + (PW+1)'(k);
      if (scan_pos >= (PW+1)'(NREQ)) scan_pos = scan_pos - (PW+1)'(NREQ);
      if (!arb_hit_d && REQ[scan_pos[PW-1:0]]) begin
        arb_hit_d = 1'b1;
        arb_idx_d = scan_pos[PW-1:0];
      end
    end
  end

  assign rr_d  = (arb_idx_d == PW'(NREQ - 1)) ? '0 : arb_idx_d + 1'b1;
  assign gnt_d = NREQ'(1) << arb_idx_d;

  assign owner_req = REQ[own_q];
  assign expire    = (timer_q == LAST);
  // The grant ends either when its owner lets go or when the hold slot runs out.
  assign slot_end  = (state_q == OWN) && (!owner_req || expire);

  // Live pattern of whoever holds GNT right now; registered into ULED.
  always_comb begin
    led_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) led_sel = LED_DATA[i*LEDW +: LEDW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      uled_q  <= '0;
    end else begin
      uled_q <= led_sel;
      case (state_q)
        IDLE: begin
          if (arb_hit_d) begin
            state_q <= OWN;
            own_q   <= arb_idx_d;
            rr_q    <= rr_d;
            timer_q <= '0;
            gnt_q   <= gnt_d;
            vld_q   <= 1'b1;
          end
        end
        OWN: begin
          if (slot_end) begin
            // rr_q already points past the owner, so any other waiting
            // requester wins; the owner is regranted only if it is alone.
            timer_q <= '0;
            if (arb_hit_d) begin
              own_q <= arb_idx_d;
              rr_q  <= rr_d;
              gnt_q <= gnt_d;
              vld_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              vld_q   <= 1'b0;
            end
          end else begin
            timer_q <= expire ? timer_q : timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign GNT         = gnt_q;
  assign GNT_VLD     = vld_q;
  assign SLOT_END    = slot_end;
  assign ULED        = uled_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uled_share_arbiter.sv
// Directed bench for uled_share_arbiter. Two instances share the same inputs:
// dut_a has HOLD=4, dut_b has HOLD=1. Each step drives one cycle of inputs,
// pushes the expected outputs for that cycle and compares them at the
// falling edge.
module tb_uled_share_arbiter;

  localparam int NREQ = 4;
  localparam int LEDW = 10;
  localparam int W    = NREQ + 2 + LEDW;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      REQ;
  logic [NREQ*LEDW-1:0] LED_DATA;

  logic [NREQ-1:0] a_gnt, b_gnt;
  logic            a_vld, b_vld;
  logic            a_se,  b_se;
  logic [LEDW-1:0] a_uled, b_uled;
  logic            a_dbg, b_dbg;

  logic [LEDW-1:0] pat [0:3];
  logic [W-1:0]    exp_q[$];
  int              n_cmp  = 0;
  int              n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    pat[0] = 10'h155;
    pat[1] = 10'h0F0;
    pat[2] = 10'h2AA;
    pat[3] = 10'h30C;
  end
  assign LED_DATA = {pat[3], pat[2], pat[1], pat[0]};

  uled_share_arbiter #(.NREQ(NREQ), .LEDW(LEDW), .HOLD(4), .CNTW(8)) dut_a (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LED_DATA(LED_DATA),
    .GNT(a_gnt), .GNT_VLD(a_vld), .SLOT_END(a_se), .ULED(a_uled),
    .dbg_state_o(a_dbg)
  );

  uled_share_arbiter #(.NREQ(NREQ), .LEDW(LEDW), .HOLD(1), .CNTW(4)) dut_b (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LED_DATA(LED_DATA),
    .GNT(b_gnt), .GNT_VLD(b_vld), .SLOT_END(b_se), .ULED(b_uled),
    .dbg_state_o(b_dbg)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / scoreboard ----------------
  // One clock cycle: drive inputs just after the rising edge, record the
  // expected outputs for this cycle, compare at the falling edge.
  task automatic cyc(input logic which, input logic rst, input logic [3:0] req,
                     input logic [3:0] eg, input logic ese, input logic [9:0] eu,
                     input string tag);
    logic [W-1:0] exp_v, obs_v;
    @(posedge CLK);
    #1;
    RST = rst;
    REQ = req;
    exp_q.push_back({eg, |eg, ese, eu});
    @(negedge CLK);
    obs_v = which ? {b_gnt, b_vld, b_se, b_uled} : {a_gnt, a_vld, a_se, a_uled};
    exp_v = exp_q.pop_front();
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // RST is high across the next rising edge; the following cyc() releases it.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    REQ = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seq [0:2];
    int own, prev;
    RST = 1'b1;
    REQ = 4'hF;
    seq[0] = 0; seq[1] = 1; seq[2] = 3;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'hF, 4'b0000, 0, 10'h0, "rst_hold");
    cyc(0, 0, 4'hF, 4'b0000, 0, 10'h0, "rst_release");
    cyc(0, 0, 4'hF, 4'b0001, 0, 10'h0, "first_grant");

    // Single requester 2, HOLD=4: continuous grant, SLOT_END every 4 cycles.
    do_reset();
    cyc(0, 0, 4'b0100, 4'b0000, 0, 10'h0, "single_idle");
    for (int k = 1; k <= 8; k++)
      cyc(0, 0, 4'b0100, 4'b0100, (k % 4 == 0), (k == 1) ? 10'h0 : pat[2], "single_hold");

    // Round robin over 0,1,3 with 4-cycle slots and no gap.
    do_reset();
    cyc(0, 0, 4'b1011, 4'b0000, 0, 10'h0, "rr_idle");
    for (int k = 1; k <= 24; k++) begin
      own  = seq[((k - 1) / 4) % 3];
      prev = (k == 1) ? 0 : seq[((k - 2) / 4) % 3];
      cyc(0, 0, 4'b1011, 4'(1 << own), (k % 4 == 0), (k == 1) ? 10'h0 : pat[prev], "rr_seq");
    end

    // Early release by owner 1 with 3 waiting, then everyone drops.
    do_reset();
    cyc(0, 0, 4'b0010, 4'b0000, 0, 10'h0,  "drop_idle");
    cyc(0, 0, 4'b1010, 4'b0010, 0, 10'h0,  "drop_own1_c0");
    cyc(0, 0, 4'b1010, 4'b0010, 0, pat[1], "drop_own1_c1");
    cyc(0, 0, 4'b1000, 4'b0010, 1, pat[1], "drop_release");
    cyc(0, 0, 4'b1000, 4'b1000, 0, pat[1], "drop_handover");
    cyc(0, 0, 4'b0000, 4'b1000, 1, pat[3], "drop_all");
    cyc(0, 0, 4'b0000, 4'b0000, 0, pat[3], "drop_idle_lag");
    cyc(0, 0, 4'b0000, 4'b0000, 0, 10'h0,  "drop_uled_clr");

    // HOLD=1 instance: alternate every cycle, ULED one cycle behind.
    do_reset();
    cyc(1, 0, 4'b0011, 4'b0000, 0, 10'h0, "h1_idle");
    for (int k = 1; k <= 8; k++)
      cyc(1, 0, 4'b0011, (k % 2 == 1) ? 4'b0001 : 4'b0010, 1,
          (k == 1) ? 10'h0 : ((k % 2 == 1) ? pat[1] : pat[0]), "h1_alt");

    // Reset mid-slot while owner 3 holds with timer=2.
    do_reset();
    cyc(0, 0, 4'b1000, 4'b0000, 0, 10'h0,  "mid_idle");
    cyc(0, 0, 4'b1000, 4'b1000, 0, 10'h0,  "mid_own3_t0");
    cyc(0, 0, 4'b1000, 4'b1000, 0, pat[3], "mid_own3_t1");
    cyc(0, 1, 4'b1001, 4'b1000, 0, pat[3], "mid_own3_t2");
    cyc(0, 0, 4'b1001, 4'b0000, 0, 10'h0,  "mid_cleared");
    cyc(0, 0, 4'b1001, 4'b0001, 0, 10'h0,  "mid_regrant0");
    cyc(0, 0, 4'b1001, 4'b0001, 0, pat[0], "mid_regrant0_led");
    // Owner 0 leaves rr_ptr at 1; reset must bring it back to 0.
    cyc(0, 1, 4'b0011, 4'b0001, 0, pat[0], "rrp_own0_t2");
    cyc(0, 0, 4'b0011, 4'b0000, 0, 10'h0,  "rrp_cleared");
    cyc(0, 0, 4'b0011, 4'b0001, 0, 10'h0,  "rrp_req0_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
